// File: rtl/rng_address_responder_pkg.sv
// Shared constants, FSM state encoding and helpers for the random-neighbour
// address responder.
package rng_address_responder_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam int unsigned ITER_COUNT = 16;
  localparam int unsigned ITER_W     = $clog2(ITER_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_SCALE,
    ST_DONE
  } state_t;

  // True for a nonzero value with exactly one bit set.
  function automatic logic is_pow2(input logic [WORD_WIDTH-1:0] value);
    return (value != '0) && ((value & (value - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/rng_address_responder_restoring_mod_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module restoring_mod_step #(
  parameter int unsigned WORD_WIDTH = rng_address_responder_pkg::WORD_WIDTH
) (
  input  logic [WORD_WIDTH-1:0] rem_in,
  input  logic                  next_bit,
  input  logic [WORD_WIDTH-1:0] divisor,
  output logic [WORD_WIDTH-1:0] rem_out
);

  // The shifted remainder needs one extra bit: rem_in < divisor, so after the
  // shift it can exceed 2^WORD_WIDTH - 1 but never 2 * divisor.
  logic [WORD_WIDTH:0] shifted;

  always_comb begin
    shifted = {rem_in, next_bit};
    rem_out = shifted[WORD_WIDTH-1:0];
    // The true difference is below divisor, so the low word alone is exact.
    if (shifted >= {1'b0, divisor}) begin
      rem_out = shifted[WORD_WIDTH-1:0] - divisor;
    end
  end

endmodule

// File: rtl/rng_address_responder.sv
// Computes which = rng_value mod neighbor_count by sequential restoring division
// and the matching neighbour-table address. Define RNG_ADDR_FAST_POW2_EN to
// resolve power-of-two counts with a mask in the accepting cycle.
module rng_address_responder #(
  parameter int unsigned                      WORD_WIDTH   = rng_address_responder_pkg::WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0]            BASE_ADDR    = 16'h0100,
  parameter int unsigned                      STRIDE_SHIFT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] rng_value,
  input  logic [WORD_WIDTH-1:0] neighbor_count,
  output logic [WORD_WIDTH-1:0] which,
  output logic [WORD_WIDTH-1:0] rng_address,
  output logic                  done,
  output logic                  count_err
);

  import rng_address_responder_pkg::*;

  state_t                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   dividend_q, dividend_d;
  logic [WORD_WIDTH-1:0]   divisor_q, divisor_d;
  logic [WORD_WIDTH-1:0]   rem_q, rem_d;
  logic [ITER_W-1:0]       iter_q, iter_d;
  logic [WORD_WIDTH-1:0]   which_d, rng_address_d;
  logic                    done_d, count_err_d;

  logic [ITER_W-1:0]       bit_idx;
  logic [WORD_WIDTH-1:0]   step_rem;
  logic [WORD_WIDTH-1:0]   scaled_rem;

  // Dividend is consumed MSB first.
  assign bit_idx    = ITER_W'(ITER_COUNT - 1) - iter_q;
  assign scaled_rem = rem_q << STRIDE_SHIFT;

  restoring_mod_step #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_step (
    .rem_in   (rem_q),
    .next_bit (dividend_q[bit_idx]),
    .divisor  (divisor_q),
    .rem_out  (step_rem)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d       = state_q;
    dividend_d    = dividend_q;
    divisor_d     = divisor_q;
    rem_d         = rem_q;
    iter_d        = iter_q;
    which_d       = which;
    rng_address_d = rng_address;
    done_d        = done;
    count_err_d   = count_err;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dividend_d  = rng_value;
          divisor_d   = neighbor_count;
          rem_d       = '0;
          iter_d      = '0;
          count_err_d = 1'b0;
          state_d     = ST_DIVIDE;
          if (neighbor_count == '0) begin
            state_d = ST_SCALE;
          end
`ifdef RNG_ADDR_FAST_POW2_EN
          else if (is_pow2(neighbor_count)) begin
            rem_d   = rng_value & (neighbor_count - 1'b1);
            state_d = ST_SCALE;
          end
`endif
        end
      end

      ST_DIVIDE: begin
        rem_d  = step_rem;
        iter_d = iter_q + 1'b1;
        if (iter_q == ITER_W'(ITER_COUNT - 1)) begin
          state_d = ST_SCALE;
        end
      end

      ST_SCALE: begin
        which_d       = rem_q;
        rng_address_d = BASE_ADDR + scaled_rem;
        done_d        = 1'b1;
        count_err_d   = (divisor_q == '0);
        state_d       = ST_DONE;
      end

      ST_DONE: begin
        // Entered with done already high, so done lasts at least one cycle.
        if (!start) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      iter_q      <= '0;
      which       <= '0;
      rng_address <= '0;
      done        <= 1'b0;
      count_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      iter_q      <= iter_d;
      which       <= which_d;
      rng_address <= rng_address_d;
      done        <= done_d;
      count_err   <= count_err_d;
    end
  end

endmodule

// File: tb/tb_rng_address_responder.sv
// Scoreboard bench for rng_address_responder: two instances (default base and
// a wrapping base) share stimulus; a monitor checks each result on done.
module tb_rng_address_responder;

  localparam logic [15:0] BASE0 = 16'h0100;
  localparam logic [15:0] BASE1 = 16'hFFFC;
  localparam int          SHIFT = 1;
`ifdef RNG_ADDR_FAST_POW2_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic [15:0] which;
    logic [15:0] addr;
    logic        err;
    int          lat;
    int          e0;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] rng_value, neighbor_count;
  logic [15:0] which0, addr0, which1, addr1;
  logic        done0, err0, done1, err1;

  int   edge_cnt = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic done0_prev = 1'b0, done1_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  rng_address_responder #(.WORD_WIDTH(16), .BASE_ADDR(BASE0), .STRIDE_SHIFT(SHIFT)) dut0 (
    .clock(clk), .reset(reset), .start(start), .rng_value(rng_value),
    .neighbor_count(neighbor_count), .which(which0), .rng_address(addr0),
    .done(done0), .count_err(err0)
  );

  rng_address_responder #(.WORD_WIDTH(16), .BASE_ADDR(BASE1), .STRIDE_SHIFT(SHIFT)) dut1 (
    .clock(clk), .reset(reset), .start(start), .rng_value(rng_value),
    .neighbor_count(neighbor_count), .which(which1), .rng_address(addr1),
    .done(done1), .count_err(err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: plain modulo arithmetic and address formula.
  function automatic exp_t model(input logic [15:0] rv, input logic [15:0] nc,
                                 input logic [15:0] base, input int e0);
    exp_t e;
    int   w;
    int   rv_i, nc_i;
    rv_i = int'({16'h0, rv});
    nc_i = int'({16'h0, nc});
    w = (nc_i == 0) ? 0 : rv_i % nc_i;
    e.which = 16'(w);
    e.addr  = 16'((int'({16'h0, base}) + (w << SHIFT)) & 32'hFFFF);
    e.err   = (nc_i == 0);
    if (nc_i == 0) e.lat = 2;
    else if (FAST && ((nc_i & (nc_i - 1)) == 0)) e.lat = 2;
    else e.lat = 18;
    e.e0 = e0;
    return e;
  endfunction

  task automatic check_result(input string tag, input exp_t e, input logic [15:0] w,
                              input logic [15:0] a, input logic err);
    check({tag, "_which"}, 32'(w), 32'(e.which));
    check({tag, "_addr"}, 32'(a), 32'(e.addr));
    check({tag, "_count_err"}, 32'(err), 32'(e.err));
    check({tag, "_latency"}, 32'(edge_cnt - e.e0 + 1), 32'(e.lat));
  endtask

  // Monitor: compare on each rising done, independent of the stimulus.
  always @(negedge clk) begin
    if (reset) begin
      done0_prev = 1'b0;
      done1_prev = 1'b0;
    end else begin
      if (done0 && !done0_prev) begin
        if (q0.size() == 0) check("dut0_unexpected_done", 32'd1, 32'd0);
        else check_result("dut0", q0.pop_front(), which0, addr0, err0);
      end
      if (done1 && !done1_prev) begin
        if (q1.size() == 0) check("dut1_unexpected_done", 32'd1, 32'd0);
        else check_result("dut1", q1.pop_front(), which1, addr1, err1);
      end
      done0_prev = done0;
      done1_prev = done1;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    q0.delete();
    q1.delete();
    reset = 1'b0;
  endtask

  task automatic run_req(input logic [15:0] rv, input logic [15:0] nc,
                         input bit early_drop, input int hold);
    int waited;
    @(negedge clk);
    rng_value      = rv;
    neighbor_count = nc;
    start          = 1'b1;
    @(negedge clk);
    q0.push_back(model(rv, nc, BASE0, edge_cnt));
    q1.push_back(model(rv, nc, BASE1, edge_cnt));
    // Inputs after acceptance must have no effect.
    rng_value      = 16'($urandom);
    neighbor_count = 16'($urandom);
    if (early_drop) start = 1'b0;
    waited = 0;
    while (!done0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!done0) begin
      check("done_timeout", 32'(done0), 32'd1);
      apply_reset();
      return;
    end
    if (!early_drop) begin
      repeat (hold) begin
        @(negedge clk);
        check("done_hold", 32'(done0 & done1), 32'd1);
      end
      start = 1'b0;
    end
    @(negedge clk);
    check("done_clear", 32'(done0 | done1), 32'd0);
  endtask

  initial begin
    logic [15:0] nc;
    logic        seen_done;
    reset = 1'b1;
    start = 1'b0;
    rng_value = '0;
    neighbor_count = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {which0, addr0}, 32'd0);
    check("reset_flags", {28'd0, done0, err0, done1, err1}, 32'd0);
    reset = 1'b0;

    run_req(16'h1234, 16'd7, 1'b0, 3);
    run_req(16'd3, 16'd10, 1'b0, 0);
    run_req(16'hABCD, 16'd1, 1'b0, 1);
    run_req(16'hBEEF, 16'd0, 1'b0, 2);
    run_req(16'h00FF, 16'd8, 1'b0, 1);
    run_req(16'd12, 16'd7, 1'b0, 0);
    run_req(16'hFFFF, 16'hFFFF, 1'b1, 0);
    run_req(16'hFFFE, 16'hFFFF, 1'b0, 0);
    run_req(16'hC001, 16'h8000, 1'b1, 0);

    // Reset 8 edges after acceptance aborts the operation.
    @(negedge clk);
    rng_value = 16'h5555;
    neighbor_count = 16'd9;
    start = 1'b1;
    @(negedge clk);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midreset_outputs", {which0, addr0}, 32'd0);
    check("midreset_flags", {28'd0, done0, err0, done1, err1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen_done = seen_done | done0 | done1;
    end
    check("midreset_no_done", 32'(seen_done), 32'd0);
    run_req(16'h5555, 16'd9, 1'b0, 1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       nc = 16'd0;
        1:       nc = 16'd1;
        2:       nc = 16'd1 << $urandom_range(0, 15);
        3:       nc = 16'($urandom_range(2, 20));
        default: nc = 16'($urandom);
      endcase
      run_req(16'($urandom), nc, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_address_responder.md
# rng_address_responder

Responder side of the winner-policy random-neighbour handshake. It accepts a start request with a random word and a better-neighbour count, then computes `which = rng_value mod neighbor_count` by sequential restoring division. It also forms the memory address of the selected neighbour entry, `rng_address = BASE_ADDR + (which << STRIDE_SHIFT)`, and raises `done`. It sits between the random generator, the winner-policy controller and the neighbour table in memory.

## Interface
- `WORD_WIDTH`, 16, datapath width of all word ports.
- `BASE_ADDR`, 16'h0100, memory address of neighbour entry 0.
- `STRIDE_SHIFT`, 1, log2 of the bytes per neighbour entry; entry stride is 2 bytes.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request level, held high by the initiator until `done` is seen.
- `rng_value`  in  16  random dividend, sampled at the accepting edge.
- `neighbor_count`  in  16  divisor, sampled at the accepting edge.
- `which`  out  16  selected neighbour index (remainder).
- `rng_address`  out  16  address of the selected entry.
- `done`  out  1  result valid; held while `start` stays high.
- `count_err`  out  1  set with `done` when `neighbor_count` was 0.

## Operation
- States:
  - IDLE: waits for `start`.
  - DIVIDE: iteration counter 0..15.
  - SCALE: forms the address.
  - DONE: presents the result.
- IDLE with `start`=1, called edge E0:
  - Capture `rng_value` and `neighbor_count`.
  - Clear the remainder and the counter.
  - Go to DIVIDE.
  - If the captured count is 0, go to SCALE with remainder 0 and set `count_err`.
- DIVIDE, one bit per cycle, MSB first:
  - `rem = {rem[14:0], dividend[15-i]}`.
  - If `rem >= count`, then `rem -= count`.
  - After 16 iterations, go to SCALE.
  - The remainder uses 17 bits internally to avoid overflow on the compare.
- SCALE:
  - `which <= rem`.
  - `rng_address <= BASE_ADDR + (rem << STRIDE_SHIFT)`, truncated to 16 bits so the address wraps mod 2^16.
  - `done <= 1`. Go to DONE.
- DONE:
  - Outputs are held stable.
  - When `start`=0 at an edge, clear `done` and go to IDLE.
  - `done` is high for at least one cycle even if `start` already dropped.
- Inputs changing after E0 are ignored until the next acceptance.
- A `start` drop during DIVIDE or SCALE is ignored; the operation completes.
- `count_err` is cleared at the next acceptance.
- `which` and `rng_address` keep their last values in IDLE.

## Timing
- Reset values: `which`=0, `rng_address`=0, `done`=0, `count_err`=0, state IDLE.
- Reset has priority over every transition. Reset mid-operation aborts with no `done`.
- Latency, counted from E0 to `done` high, normal path: 18 edges (E0 + 16 DIVIDE + SCALE).
- Latency for count 0: 2 edges (E0 + SCALE).
- Back-to-back requests: after the DONE→IDLE edge, the next accept happens no earlier than the following edge. Minimum 1 idle cycle.
- No combinational path from inputs to outputs.

## Configuration
- `RNG_ADDR_FAST_POW2_EN` defined:
  - At E0, if `neighbor_count` is a nonzero power of two, `rem = rng_value & (count-1)`.
  - Go directly to SCALE. Latency 2 edges.
- Undefined:
  - Powers of two take the full 18-edge DIVIDE path.
  - Results are identical in both builds; only latency differs.

## Structure
- Shared package:
  - `WORD_WIDTH` constant.
  - State encoding typedef (IDLE/DIVIDE/SCALE/DONE).
  - Iteration count constant 16.
- One sub-module, `restoring_mod_step`:
  - Combinational single-bit restoring step.
  - Inputs: `rem_in`, `next_bit`, `divisor`. Output: `rem_out`.
  - Instantiated once and used each DIVIDE cycle.
- The FSM, counter and address arithmetic live in `rng_address_responder`.

## Test plan
- `rng_value`=0x1234, `neighbor_count`=7, BASE 0x0100 → `which`=5, `rng_address`=0x010A, `done` 18 edges after E0, `count_err`=0.
- `rng_value`=3, `neighbor_count`=10 → `which`=3, `rng_address`=0x0106. With count 1, any value → `which`=0.
- `neighbor_count`=0, `rng_value`=0xBEEF → `which`=0, `rng_address`=0x0100, `count_err`=1, `done` after 2 edges.
- `rng_value`=0x00FF, `neighbor_count`=8 → `which`=7, `rng_address`=0x010E. Latency is 2 edges with `RNG_ADDR_FAST_POW2_EN`, 18 without.
- BASE_ADDR=16'hFFFC, `rng_value`=12, `neighbor_count`=7 → `which`=5, `rng_address`=0x0006 (wrap).
- Handshake and reset:
  - Hold `start` high: `done` persists; drop `start` → `done`=0 next edge.
  - Assert `reset` 8 edges after E0: all outputs 0, no `done`.
  - A fresh request then completes correctly.
